// File: rtl/matmul_pkg.sv
// Shared state encoding and layout constants for the matmul writeback stage.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_R,
    HDR_C,
    DATA,
    DONE
  } state_t;

  localparam int unsigned HDR_BYTES  = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous element FIFO between the result stream and the write port.
module wb_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/matmul_writeback.sv
// Stores result matrix C as {rows, cols, row-major data} through a stallable write port.
module matmul_writeback
  import matmul_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     addr_c,
  input  logic [AW-1:0]     num_rows,
  input  logic [AW-1:0]     num_cols,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_i,
  input  logic [AW-1:0]     in_j,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic              mem_stall,
  output logic              busy,
  output logic              done,
  output logic              err_idx
);

  localparam int unsigned FIFO_W = 2*AW + DATA_W;

  state_t state, state_n;

  logic [AW-1:0]     base_q, rows_q, cols_q, total_q;
  logic [AW-1:0]     cnt, cnt_n;
  logic              we_n, err_n;
  logic [AW-1:0]     addr_n;
  logic [DATA_W-1:0] wd_n;

  logic              accept_start;
  logic              commit;
  logic              load;
  logic              pop;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [AW-1:0]     head_i, head_j;
  logic [DATA_W-1:0] head_data;
  logic              head_ok;
  logic [AW-1:0]     lin_idx;
  logic [AW-1:0]     elem_addr;

  assign accept_start = (state == IDLE) && start;
  assign commit       = mem_we && !mem_stall;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign in_ready     = !fifo_full &&
                        ((state == HDR_R) || (state == HDR_C) || (state == DATA));
  assign push         = in_valid && in_ready;

  assign {head_i, head_j, head_data} = fifo_rdata;
  assign head_ok   = (head_i < rows_q) && (head_j < cols_q);
  assign lin_idx   = head_i * cols_q + head_j;
  assign elem_addr = base_q + AW'(HDR_BYTES) + lin_idx * AW'(WORD_BYTES);

  wb_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (accept_start),
    .push  (push),
    .pop   (pop),
    .wdata ({in_i, in_j, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n = state;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wd_n    = mem_wd;
    cnt_n   = cnt;
    err_n   = err_idx;
    load    = 1'b0;
    pop     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = HDR_R;
          we_n    = 1'b1;
          addr_n  = addr_c;
          wd_n    = num_rows;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end
      HDR_R: begin
        if (commit) begin
          state_n = HDR_C;
          addr_n  = base_q + AW'(WORD_BYTES);
          wd_n    = cols_q;
        end
      end
      HDR_C: begin
        if (commit) begin
          if (total_q == '0) begin
            state_n = DONE;
            we_n    = 1'b0;
          end else begin
            state_n = DATA;
            load    = 1'b1;
          end
        end
      end
      DATA: begin
        if (commit) cnt_n = cnt + AW'(1);
        if (cnt_n == total_q) begin
          state_n = DONE;
          we_n    = 1'b0;
        end else if (!mem_we || commit) begin
          load = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        we_n    = 1'b0;
      end
      default: begin
        state_n = IDLE;
        we_n    = 1'b0;
      end
    endcase

    // The write register is refilled from the FIFO head whenever it is free;
    // out-of-range heads are consumed with the strobe low.
    if (load) begin
      we_n = 1'b0;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (head_ok) begin
          we_n   = 1'b1;
          addr_n = elem_addr;
          wd_n   = head_data;
        end else begin
          err_n  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      cnt      <= '0;
      err_idx  <= 1'b0;
      base_q   <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      total_q  <= '0;
    end else begin
      state    <= state_n;
      mem_we   <= we_n;
      mem_addr <= addr_n;
      mem_wd   <= wd_n;
      cnt      <= cnt_n;
      err_idx  <= err_n;
      if (accept_start) begin
        base_q  <= addr_c;
        rows_q  <= num_rows;
        cols_q  <= num_cols;
        total_q <= num_rows * num_cols;
      end
    end
  end

endmodule

// File: tb/tb_matmul_writeback.sv
// Randomized bench for matmul_writeback against a write-sequence reference model.
module tb_matmul_writeback;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr_c = '0, num_rows = '0, num_cols = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_i = '0, in_j = '0, in_data = '0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_stall = 1'b0;
  logic        busy, done, err_idx;

  matmul_writeback #(.FIFO_DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .addr_c(addr_c),
    .num_rows(num_rows), .num_cols(num_cols), .in_valid(in_valid),
    .in_ready(in_ready), .in_i(in_i), .in_j(in_j), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_stall(mem_stall), .busy(busy), .done(done), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] i; logic [31:0] j; logic [31:0] d; } elem_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  int          checks = 0;
  int          errors = 0;
  elem_t       elems[$];
  int unsigned idx;
  bit          acc;

  wr_t         exp_q[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  bit          m_busy = 0, done_pend = 0, clr_pend = 0, stall_prev = 0, m_err = 0;
  logic [31:0] prev_addr, prev_wd;
  logic [31:0] m_base, m_rows, m_cols, m_total, m_acc;
  int unsigned m_commits, m_needed;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the job is the ordered list of writes header, header, then
  // the first rows*cols in-range elements in acceptance order.
  always @(negedge clk) begin
    bit nb, ndp;
    wr_t e;
    if (!reset) begin
      exp_q.delete();
      m_busy = 0; done_pend = 0; clr_pend = 0; stall_prev = 0;
      chk("reset_flags", {27'b0, mem_we, in_ready, busy, done, err_idx}, 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wd", mem_wd, 32'h0);
    end else begin
      nb = m_busy;
      ndp = 0;
      chk("done", {31'b0, done}, {31'b0, done_pend});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      if (done) done_cnt++;
      if (done_pend) begin
        chk("err_idx_at_done", {31'b0, err_idx}, {31'b0, m_err});
        nb = 0;
      end
      if (!m_busy) chk("in_ready_idle", {31'b0, in_ready}, 32'h0);
      if (clr_pend) chk("err_idx_cleared", {31'b0, err_idx}, 32'h0);
      clr_pend = 0;
      if (stall_prev) begin
        chk("stall_hold_we", {31'b0, mem_we}, 32'h1);
        chk("stall_hold_addr", mem_addr, prev_addr);
        chk("stall_hold_wd", mem_wd, prev_wd);
      end
      stall_prev = mem_we && mem_stall;
      prev_addr = mem_addr;
      prev_wd = mem_wd;
      if (m_busy && in_valid && in_ready) begin
        if (in_i < m_rows && in_j < m_cols) begin
          if (m_acc < m_total) begin
            exp_q.push_back('{a: m_base + 32'd8 + 32'd4 * (in_i * m_cols + in_j), d: in_data});
            m_acc++;
          end
        end else begin
          m_err = 1;
        end
      end
      if (mem_we && !mem_stall) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write: got addr 0x%08h data 0x%08h, required no write", mem_addr, mem_wd);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", mem_addr, e.a);
          chk("write_data", mem_wd, e.d);
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wd);
          m_commits++;
          if (m_commits == m_needed) ndp = 1;
        end
      end
      if (!m_busy && start) begin
        m_base = addr_c; m_rows = num_rows; m_cols = num_cols;
        m_total = num_rows * num_cols;
        m_acc = 0; m_err = 0; m_commits = 0;
        m_needed = 2 + m_total;
        exp_q.delete();
        exp_q.push_back('{a: addr_c, d: num_rows});
        exp_q.push_back('{a: addr_c + 32'd4, d: num_cols});
        nb = 1;
        clr_pend = 1;
      end
      m_busy = nb;
      done_pend = ndp;
    end
  end

  task automatic drive_cycle(input bit stall, input bit gap);
    mem_stall = stall;
    if (!in_valid && idx < elems.size() && (!gap || $urandom_range(0, 3) != 0)) begin
      in_valid = 1'b1;
      in_i = elems[idx].i;
      in_j = elems[idx].j;
      in_data = elems[idx].d;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (acc) begin
      idx++;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] rows, input logic [31:0] cols);
    log_addr.delete();
    log_data.delete();
    idx = 0;
    in_valid = 1'b0;
    addr_c = base; num_rows = rows; num_cols = cols;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] base, input logic [31:0] rows, input logic [31:0] cols,
                         input int unsigned stall_pct, input bit gap, input int unsigned hold);
    int unsigned cyc;
    int d0;
    bit st;
    do_start(base, rows, cols);
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 500) begin
      st = (cyc < hold) || ($urandom_range(0, 99) < stall_pct);
      drive_cycle(st, gap);
      cyc++;
      if (hold != 0 && cyc == hold) begin
        chk("fill_accepted", idx, DEPTH);
        chk("fill_in_ready", {31'b0, in_ready}, 32'h0);
      end
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL job_timeout: got no done after %0d cycles, required done", cyc);
    end
    chk("all_accepted", idx, elems.size());
    in_valid = 1'b0;
    mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic build(input int unsigned rows, input int unsigned cols, input bit shuffle);
    elem_t t;
    int unsigned k;
    elems.delete();
    for (int unsigned r = 0; r < rows; r++)
      for (int unsigned c = 0; c < cols; c++)
        elems.push_back('{i: r, j: c, d: $urandom()});
    if (shuffle && elems.size() > 1)
      for (int n = elems.size() - 1; n > 0; n--) begin
        k = $urandom_range(0, n);
        t = elems[n]; elems[n] = elems[k]; elems[k] = t;
      end
  endtask

  logic [31:0] t1_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
  logic [31:0] t1_data [6] = '{32'd2, 32'd2, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    elem_t e;
    int unsigned rows, cols, pos;
    logic [31:0] base;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // 2x2 back-to-back, no stall, literal write sequence
    elems.delete();
    elems.push_back('{i: 0, j: 0, d: 32'h3F800000});
    elems.push_back('{i: 0, j: 1, d: 32'h40000000});
    elems.push_back('{i: 1, j: 0, d: 32'h40400000});
    elems.push_back('{i: 1, j: 1, d: 32'h40800000});
    run_job(32'h100, 2, 2, 0, 0, 0);
    chk("t1_nwrites", log_addr.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < log_addr.size()) begin
        chk("t1_addr", log_addr[k], t1_addr[k]);
        chk("t1_data", log_data[k], t1_data[k]);
      end

    // 2x3 out of order with (1,2) first
    build(2, 3, 1);
    for (int k = 0; k < elems.size(); k++)
      if (elems[k].i == 1 && elems[k].j == 2) begin
        e = elems[k];
        elems.delete(k);
        break;
      end
    elems.push_front(e);
    run_job(32'h100, 2, 3, 0, 1, 0);
    chk("t2_nwrites", log_addr.size(), 8);
    if (log_addr.size() > 2) begin
      chk("t2_first_data_addr", log_addr[2], 32'h11C);
      chk("t2_first_data_val", log_data[2], e.d);
    end

    // stall from start: FIFO fills to its depth, then random stalls
    build(3, 3, 1);
    run_job(32'h2000, 3, 3, 35, 0, 8);
    chk("t3_nwrites", log_addr.size(), 11);

    // empty matrix: only the two header words
    elems.delete();
    run_job(32'h300, 0, 0, 20, 1, 0);
    chk("t4_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("t4_hdr_rows", log_data[0], 32'h0);
      chk("t4_hdr_cols_addr", log_addr[1], 32'h304);
      chk("t4_hdr_cols", log_data[1], 32'h0);
    end

    // out-of-range (2,0) on a 2x2
    build(2, 2, 1);
    elems.push_front('{i: 2, j: 0, d: 32'hDEADBEEF});
    run_job(32'h400, 2, 2, 10, 1, 0);
    chk("t5_err_sticky", {31'b0, err_idx}, 32'h1);
    chk("t5_nwrites", log_addr.size(), 6);

    // async reset mid-DATA with FIFO occupied
    build(3, 3, 0);
    do_start(32'h500, 3, 3);
    for (int c = 0; c < 12; c++) drive_cycle(c >= 4, 0);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_we", {31'b0, mem_we}, 32'h0);
    chk("t6_async_busy", {31'b0, busy}, 32'h0);
    chk("t6_async_ready", {31'b0, in_ready}, 32'h0);
    in_valid = 1'b0;
    mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // randomized jobs: wrap-around base, duplicates, out-of-range, stalls
    for (int n = 0; n < 12; n++) begin
      rows = $urandom_range(0, 4);
      cols = $urandom_range(0, 4);
      base = (n == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      build(rows, cols, 1);
      if (elems.size() >= 2 && $urandom_range(0, 2) == 0) begin
        e = elems[0];
        e.d = $urandom();
        elems[elems.size() - 1] = e;
      end
      if (elems.size() > 0 && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) e = '{i: rows + $urandom_range(0, 2), j: $urandom_range(0, cols - 1), d: $urandom()};
        else                           e = '{i: $urandom_range(0, rows - 1), j: cols + $urandom_range(0, 2), d: $urandom()};
        pos = $urandom_range(0, elems.size() - 1);
        elems.insert(pos, e);
      end
      run_job(base, rows, cols, $urandom_range(0, 40), 1, 0);
      chk("rand_nwrites", log_addr.size(), 2 + rows * cols);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
